// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-style control sequencer:
// opcode/funct constants, FSM state codes, field widths and the decode bundle.
package mips_pkg;

    localparam int OP_W  = 6;
    localparam int REG_W = 4;
    localparam int FN_W  = 6;
    localparam int IMM_W = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h10;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h11;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h12;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h18;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h19;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h1A;
    localparam logic [OP_W-1:0] OP_MOVI  = 6'h30;
    localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

    localparam logic [FN_W-1:0] FN_ADD  = 6'h08;
    localparam logic [FN_W-1:0] FN_MOV  = 6'h30;
    localparam logic [FN_W-1:0] FN_CMOV = 6'h31;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef struct packed {
        logic [REG_W-1:0] rs_addr;
        logic [REG_W-1:0] rt_addr;
        logic [REG_W-1:0] wr_addr;
        logic [FN_W-1:0]  alu_fn;
        logic             alu_src_imm;
        logic [31:0]      imm_ext;
        logic             is_cmov;
        logic             is_halt;
        logic             is_illegal;
    } dec_t;

    function automatic logic fn_legal(input logic [FN_W-1:0] fn);
        return fn inside {[6'h08:6'h0D], [6'h10:6'h14], [6'h19:6'h1B], 6'h28, FN_MOV, FN_CMOV};
    endfunction

    function automatic logic op_itype(input logic [OP_W-1:0] op);
        return op inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                          OP_SLTI, OP_SLTIU, OP_LUI, OP_MOVI};
    endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction decode: field extraction, ALU select, destination
// select and classification (cmov / halt / illegal).
module mips_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [OP_W-1:0] opcode;
    logic [FN_W-1:0] funct;
    logic            rtype;
    logic            itype;
    logic            move;
    logic            unused_bits;

    assign opcode      = instr[31:26];
    assign funct       = instr[8:3];
    assign rtype       = (opcode == OP_RTYPE);
    assign itype       = op_itype(opcode);
    assign unused_bits = ^{instr[13:9], instr[2:0]};

    // MOV/CMOV write back into rs and take their operand from rt
    assign move = rtype && (funct == FN_MOV || funct == FN_CMOV);

    always_comb begin
        dec             = '0;
        dec.rs_addr     = instr[25:22];
        dec.rt_addr     = instr[21:18];
        dec.imm_ext     = {{(32-IMM_W){1'b0}}, instr[17:2]};
        dec.alu_fn      = rtype ? funct : opcode;
        dec.alu_src_imm = itype;
        dec.is_cmov     = rtype && (funct == FN_CMOV);
        dec.is_halt     = (opcode == OP_HALT);
        dec.is_illegal  = rtype ? !fn_legal(funct) : !(itype || dec.is_halt);
        if (move)
            dec.wr_addr = instr[25:22];
        else if (rtype)
            dec.wr_addr = instr[17:14];
        else
            dec.wr_addr = instr[21:18];
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/WB loop with pc tracking.
// Optional PERF_CNT_EN adds busy-cycle and retired-instruction counters.
module mips_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [3:0]      rs_addr,
    output logic [3:0]      rt_addr,
    input  logic            rs_nz,
    output logic [5:0]      alu_fn,
    output logic            alu_src_imm,
    output logic [31:0]     imm_ext,
    output logic            wr_en,
    output logic [3:0]      wr_addr,
    output logic            busy,
    output logic            halted,
    output logic            illegal
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]     cyc_cnt,
    output logic [31:0]     ret_cnt
`endif
);

    logic [2:0]      state;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            cmov_ok;
    dec_t            dec;

    mips_decode u_decode (
        .instr (instr),
        .dec   (dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            cmov_ok <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:   if (start) state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr <= imem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec.is_halt) begin
                        state <= ST_HALT;
                    end else if (dec.is_illegal) begin
                        pc    <= pc + PC_W'(4);
                        state <= ST_FETCH;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cmov_ok <= rs_nz;
                    state   <= ST_WB;
                end
                ST_WB: begin
                    pc    <= pc + PC_W'(4);
                    state <= ST_FETCH;
                end
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are masked by rst so an abort during WB/DECODE leaves no side effect
    assign wr_en       = (state == ST_WB) && !rst && (!dec.is_cmov || cmov_ok);
    assign illegal     = (state == ST_DECODE) && !rst && dec.is_illegal;
    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc;
    assign busy        = (state != ST_IDLE) && (state != ST_HALT);
    assign halted      = (state == ST_HALT);
    assign rs_addr     = dec.rs_addr;
    assign rt_addr     = dec.rt_addr;
    assign alu_fn      = dec.alu_fn;
    assign alu_src_imm = dec.alu_src_imm;
    assign imm_ext     = dec.imm_ext;
    assign wr_addr     = dec.wr_addr;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (busy)            cyc_cnt <= cyc_cnt + 32'd1;
            if (state == ST_WB)  ret_cnt <= ret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Self-checking bench for mips_ctrl_fsm: directed scenarios plus random stream
// checked every cycle against a transaction-level model.
module tb_mips_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst, start, imem_valid, rs_nz;
    logic [31:0] imem_rdata;
    logic        imem_req, alu_src_imm, wr_en, busy, halted, illegal;
    logic [31:0] imem_addr, imm_ext;
    logic [3:0]  rs_addr, rt_addr, wr_addr;
    logic [5:0]  alu_fn;
`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    always #5 clk = ~clk;

    mips_ctrl_fsm #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_nz(rs_nz),
        .alu_fn(alu_fn), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .halted(halted), .illegal(illegal)
`ifdef PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [5:0] r_fns [17] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h10, 6'h11,
                               6'h12, 6'h13, 6'h14, 6'h19, 6'h1A, 6'h1B, 6'h28, 6'h30, 6'h31};
    logic [5:0] i_ops [9]  = '{6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h30};

    // instruction class: 0 illegal, 1 R-type, 2 I-type, 3 halt
    function automatic int kind(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[8:3];
        if (op == 6'h3F) return 3;
        if (op == 6'h00) begin
            foreach (r_fns[i]) if (r_fns[i] == fn) return 1;
            return 0;
        end
        foreach (i_ops[i]) if (i_ops[i] == op) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] dest_of(input logic [31:0] w);
        if (kind(w) == 2) return w[21:18];
        if (w[8:3] == 6'h30 || w[8:3] == 6'h31) return w[25:22];
        return w[17:14];
    endfunction

    function automatic bit is_cmov(input logic [31:0] w);
        return kind(w) == 1 && w[8:3] == 6'h31;
    endfunction

    // model: stage 0 waiting for fetch, 1 decode, 2 exec, 3 writeback
    bit          m_idle = 1'b1, m_halt = 1'b0, m_cok = 1'b0;
    int          m_stage = 0;
    logic [31:0] m_pc = '0, m_instr = '0, m_cyc = '0, m_ret = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle <= 1'b1; m_halt <= 1'b0; m_stage <= 0; m_pc <= '0;
            m_instr <= '0; m_cok <= 1'b0; m_cyc <= '0; m_ret <= '0;
        end else if (!m_halt) begin
            if (!m_idle) m_cyc <= m_cyc + 1;
            if (m_idle) begin
                if (start) begin m_idle <= 1'b0; m_stage <= 0; end
            end else begin
                case (m_stage)
                    0: if (imem_valid) begin m_instr <= imem_rdata; m_stage <= 1; end
                    1: begin
                        if (kind(m_instr) == 3) m_halt <= 1'b1;
                        else if (kind(m_instr) == 0) begin m_pc <= m_pc + 4; m_stage <= 0; end
                        else m_stage <= 2;
                    end
                    2: begin m_cok <= rs_nz; m_stage <= 3; end
                    default: begin m_pc <= m_pc + 4; m_stage <= 0; m_ret <= m_ret + 1; end
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        bit bz, ewr;
        bz  = !m_idle && !m_halt;
        ewr = bz && m_stage == 3 && !rst && (!is_cmov(m_instr) || m_cok);
        chk("busy", busy, bz);
        chk("halted", halted, m_halt);
        chk("imem_req", imem_req, bz && m_stage == 0);
        chk("imem_addr", imem_addr, m_pc);
        chk("wr_en", wr_en, ewr);
        if (ewr) chk("wr_addr", wr_addr, dest_of(m_instr));
        chk("illegal", illegal, bz && m_stage == 1 && !rst && kind(m_instr) == 0);
        if (bz && m_stage >= 1 && (kind(m_instr) == 1 || kind(m_instr) == 2)) begin
            chk("rs_addr", rs_addr, m_instr[25:22]);
            chk("rt_addr", rt_addr, m_instr[21:18]);
            chk("alu_fn", alu_fn, kind(m_instr) == 1 ? m_instr[8:3] : m_instr[31:26]);
            chk("alu_src_imm", alu_src_imm, kind(m_instr) == 2);
            chk("imm_ext", imm_ext, {16'h0, m_instr[17:2]});
        end
`ifdef PERF_CNT_EN
        chk("cyc_cnt", cyc_cnt, m_cyc);
        chk("ret_cnt", ret_cnt, m_ret);
`endif
    endtask

    task automatic cyc(input bit s, input bit v, input logic [31:0] d, input bit nz, input bit r);
        @(negedge clk);
        start = s; imem_valid = v; imem_rdata = d; rs_nz = nz; rst = r;
        #1 check_all();
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 99);
        if (k < 45) begin
            w[31:26] = 6'h00;
            w[8:3]   = r_fns[$urandom_range(0, 16)];
        end else if (k < 85) begin
            w[31:26] = i_ops[$urandom_range(0, 8)];
        end else if (k < 88) begin
            w[31:26] = 6'h3F;
        end
        return w;
    endfunction

    logic [31:0] i_add, i_addi, i_cmov, i_ill, i_halt;

    initial begin
        i_add  = {6'h00, 4'd1, 4'd2, 4'd8, 5'd0, 6'h08, 3'd0};
        i_addi = {6'h08, 4'd1, 4'd2, 16'd5, 2'd0};
        i_cmov = {6'h00, 4'd5, 4'd1, 4'd0, 5'd0, 6'h31, 3'd0};
        i_ill  = {6'h00, 4'd3, 4'd4, 4'd6, 5'd0, 6'h3E, 3'd0};
        i_halt = 32'hFC00_0000;
        start = 0; imem_valid = 0; imem_rdata = '0; rs_nz = 0; rst = 1;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst busy", busy, 0);
        chk("rst imem_addr", imem_addr, 0);
        chk("rst alu_fn", alu_fn, 0);

        // ADD R8 = R1 + R2, zero-wait fetch
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, i_add, 0, 0);   chk("add req", imem_req, 1);
        cyc(0, 0, 0, 0, 0);       chk("add fn", alu_fn, 6'h08); chk("add src", alu_src_imm, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);       chk("add wr_en", wr_en, 1); chk("add wr_addr", wr_addr, 8);
        // ADDI R2 = R1 + 5
        cyc(0, 1, i_addi, 0, 0);  chk("addi pc", imem_addr, 4);
        cyc(0, 0, 0, 0, 0);       chk("addi fn", alu_fn, 6'h08); chk("addi src", alu_src_imm, 1);
                                  chk("addi imm", imm_ext, 5);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);       chk("addi wr_en", wr_en, 1); chk("addi wr_addr", wr_addr, 2);
        // CMOV taken, then not taken
        cyc(0, 1, i_cmov, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);       chk("cmov1 wr_en", wr_en, 1); chk("cmov1 wr_addr", wr_addr, 5);
        cyc(0, 1, i_cmov, 0, 0);  chk("cmov0 pc", imem_addr, 32'hC);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);       chk("cmov0 wr_en", wr_en, 0);
        // fetch stalled three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, i_add, 0, 0);
            chk("stall req", imem_req, 1); chk("stall addr", imem_addr, 32'h10);
        end
        cyc(0, 1, i_ill, 0, 0);
        cyc(0, 0, 0, 0, 0);       chk("ill pulse", illegal, 1); chk("ill wr_en", wr_en, 0);
        cyc(0, 1, i_add, 0, 0);   chk("ill next addr", imem_addr, 32'h14);
        cyc(0, 0, 0, 0, 0);       chk("ill once", illegal, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);       chk("rst-wb wr_en", wr_en, 0);
        cyc(0, 0, 0, 0, 0);       chk("rst-wb busy", busy, 0); chk("rst-wb pc", imem_addr, 0);
        // HALT is sticky; start ignored
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, i_halt, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);       chk("halt halted", halted, 1); chk("halt busy", busy, 0);
        cyc(1, 1, i_add, 0, 0);   chk("halt sticky", halted, 1);
        cyc(0, 0, 0, 0, 1);

        // random stream
        for (int n = 0; n < 4000; n++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, gen(),
                $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
